// File: rtl/c2c_pkg.sv
// Shared types for the core-to-chip bus blocks.
package c2c_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } arb_grant_e;

endpackage

// File: rtl/pipeline_pkg.sv
// Core-wide pipeline parameters shared by the bus-side blocks.
package pipeline;
  localparam int unsigned XLEN = 64;
endpackage

// File: rtl/c2c_rr_pick2.sv
// Two-way round-robin pick: on a tie, the side that did not win last time wins.
module c2c_rr_pick2
  import c2c_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_grant_e last,
  output logic       valid,
  output arb_grant_e grant
);

  // Pure combinational decision; the caller registers the result.
  always_comb begin
    valid = req_i | req_d;
    grant = GRANT_INSTR;
    if (req_i && req_d) begin
      grant = (last == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    end else if (req_d) begin
      grant = GRANT_DATA;
    end
  end

endmodule

// File: rtl/c2c_mem_arbiter.sv
// Shares one memory port between instruction fetch and data masters,
// one transaction in flight, with a watchdog for hung slaves.
module c2c_mem_arbiter
  import c2c_pkg::*;
#(
  parameter int unsigned XLEN           = pipeline::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_re,
  input  logic [XLEN/8-1:0] instr_sel,
  input  logic [XLEN-1:0]   instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic              data_re,
  input  logic              data_we,
  input  logic [XLEN/8-1:0] data_sel,
  input  logic [XLEN-1:0]   data_addr,
  input  logic [XLEN-1:0]   data_w,
  output logic              data_ack,
  output logic [XLEN-1:0]   data_r,
  output logic              mem_re,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_w,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_r,
  output logic              err_timeout
);

  localparam int unsigned SEL_W = XLEN / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  arb_state_e        state_q, state_d;
  arb_grant_e        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              re_d, we_d, err_d;
  logic [SEL_W-1:0]  sel_d;
  logic [XLEN-1:0]   addr_d, w_d;
  logic              pick_valid;
  arb_grant_e        pick_grant;
  logic              expire;
  logic              done;
  logic [31:0]       fetch_word;

  c2c_rr_pick2 u_pick (
    .req_i (instr_re),
    .req_d (data_re | data_we),
    .last  (last_q),
    .valid (pick_valid),
    .grant (pick_grant)
  );

  // Watchdog fires on the TIMEOUT_CYCLES-th busy cycle without a slave ack.
  assign expire = (TIMEOUT_CYCLES != 0) && !mem_ack &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done   = mem_ack || expire;

  // Pick the 32-bit instruction word out of a wide bus beat.
  if (XLEN == 64) begin : g_fetch64
    assign fetch_word = mem_addr[2] ? mem_r[63:32] : mem_r[31:0];
  end else begin : g_fetch32
    assign fetch_word = mem_r[31:0];
  end

  // Master-side completion is combinational in the ack cycle; timeout returns zero data.
  assign instr_ack  = (state_q == ARB_BUSY_I) && done;
  assign data_ack   = (state_q == ARB_BUSY_D) && done;
  assign instr_data = ((state_q == ARB_BUSY_I) && mem_ack) ? fetch_word : 32'd0;
  assign data_r     = ((state_q == ARB_BUSY_D) && mem_ack) ? mem_r : '0;

  // Next-state and next memory command.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_timeout;
    re_d    = mem_re;
    we_d    = mem_we;
    sel_d   = mem_sel;
    addr_d  = mem_addr;
    w_d     = mem_w;
    unique case (state_q)
      ARB_IDLE: begin
        re_d = 1'b0;
        we_d = 1'b0;
        if (pick_valid) begin
          cnt_d  = '0;
          last_d = pick_grant;
          if (pick_grant == GRANT_INSTR) begin
            state_d = ARB_BUSY_I;
            re_d    = 1'b1;
            sel_d   = instr_sel;
            addr_d  = instr_addr;
            w_d     = '0;
          end else begin
            state_d = ARB_BUSY_D;
            we_d    = data_we;
            re_d    = data_re & ~data_we;
            sel_d   = data_sel;
            addr_d  = data_addr;
            w_d     = data_w;
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (done) begin
          state_d = ARB_IDLE;
          re_d    = 1'b0;
          we_d    = 1'b0;
          if (!mem_ack) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        re_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State, arbitration history, watchdog and registered memory command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      last_q      <= GRANT_DATA;
      cnt_q       <= '0;
      err_timeout <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_sel     <= '0;
      mem_addr    <= '0;
      mem_w       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_timeout <= err_d;
      mem_re      <= re_d;
      mem_we      <= we_d;
      mem_sel     <= sel_d;
      mem_addr    <= addr_d;
      mem_w       <= w_d;
    end
  end

endmodule

// File: tb/tb_c2c_mem_arbiter.sv
// Self-checking bench for c2c_mem_arbiter: vector table, corner sequences, random run.
module tb_c2c_mem_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TMO  = 4;

  logic            clk, reset_n;
  logic            instr_re, instr_ack;
  logic [7:0]      instr_sel;
  logic [63:0]     instr_addr;
  logic [31:0]     instr_data;
  logic            data_re, data_we, data_ack;
  logic [7:0]      data_sel;
  logic [63:0]     data_addr, data_w, data_r;
  logic            mem_re, mem_we, mem_ack, err_timeout;
  logic [7:0]      mem_sel;
  logic [63:0]     mem_addr, mem_w, mem_r;

  int n_tests = 0;
  int n_fail  = 0;

  c2c_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data),
    .data_re(data_re), .data_we(data_we), .data_sel(data_sel),
    .data_addr(data_addr), .data_w(data_w), .data_ack(data_ack), .data_r(data_r),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_w(mem_w), .mem_ack(mem_ack), .mem_r(mem_r), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ire, dre, dwe;
    logic [63:0] iaddr, daddr, dw;
    logic [7:0]  isel, dsel;
    logic [63:0] mr;
    int          lat;
    logic        exp_d;
    logic        exp_re, exp_we;
    logic [63:0] exp_addr, exp_w;
    logic [7:0]  exp_sel;
    logic [31:0] exp_idata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    instr_re = 1'b0; instr_sel = 8'h0; instr_addr = 64'h0;
    data_re = 1'b0; data_we = 1'b0; data_sel = 8'h0; data_addr = 64'h0; data_w = 64'h0;
    mem_ack = 1'b0; mem_r = 64'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    instr_re = v.ire; instr_addr = v.iaddr; instr_sel = v.isel;
    data_re = v.dre; data_we = v.dwe; data_addr = v.daddr; data_w = v.dw; data_sel = v.dsel;
    mem_ack = 1'b0; mem_r = v.mr;
    #1 chk("vec_idle_strobes", 64'({mem_re, mem_we}), 64'h0);
    for (int a = 1; a <= v.lat; a++) begin
      @(negedge clk);
      mem_ack = (a == v.lat);
      #1;
      chk("vec_mem_re", 64'(mem_re), 64'(v.exp_re));
      chk("vec_mem_we", 64'(mem_we), 64'(v.exp_we));
      chk("vec_mem_addr", mem_addr, v.exp_addr);
      chk("vec_mem_w", mem_w, v.exp_w);
      chk("vec_mem_sel", 64'(mem_sel), 64'(v.exp_sel));
      chk("vec_instr_ack", 64'(instr_ack), 64'((a == v.lat) && !v.exp_d));
      chk("vec_data_ack", 64'(data_ack), 64'((a == v.lat) && v.exp_d));
      chk("vec_instr_data", 64'(instr_data), ((a == v.lat) && !v.exp_d) ? 64'(v.exp_idata) : 64'h0);
      chk("vec_data_r", data_r, ((a == v.lat) && v.exp_d) ? v.mr : 64'h0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("vec_gap_strobes", 64'({mem_re, mem_we}), 64'h0);
    chk("vec_gap_acks", 64'({instr_ack, data_ack}), 64'h0);
  endtask

  vec_t vecs[6];

  // Random-phase reference state (transaction level).
  int          m_own;   // 0 none, 1 instr, 2 data
  int          m_age, m_lat;
  logic        m_last_d, m_err;
  logic        c_re, c_we;
  logic [63:0] c_addr, c_w;
  logic [7:0]  c_sel;
  logic        pi, pd, dre_r, dwe_r, ack, expire, done;
  logic [63:0] ia, da, dw, mr;
  logic [7:0]  isel_r, dsel_r;

  initial begin
    reset_n = 1'b0;
    idle_inputs();

    vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h1004, 64'h0, 64'h0, 8'hFF, 8'h00,
                64'hDEADBEEF_12345678, 2, 1'b0, 1'b1, 1'b0, 64'h1004, 64'h0, 8'hFF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h2008, 64'h4000, 64'h1111, 8'hF0, 8'hFF,
                64'hCAFE0000_0000BABE, 1, 1'b1, 1'b1, 1'b0, 64'h4000, 64'h1111, 8'hFF, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 64'h1010, 64'h4008, 64'h0, 8'h0F, 8'h0F,
                64'h01234567_89ABCDEF, 3, 1'b0, 1'b1, 1'b0, 64'h1010, 64'h0, 8'h0F, 32'h89ABCDEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h2000, 64'hA5A5A5A5_A5A5A5A5, 8'h00, 8'h0F,
                64'h0, 1, 1'b1, 1'b0, 1'b1, 64'h2000, 64'hA5A5A5A5_A5A5A5A5, 8'h0F, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h1000, 64'h0, 64'h0, 8'hFF, 8'h00,
                64'hDEADBEEF_12345678, 1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h0, 8'hFF, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 64'h1004, 64'h5000, 64'h5555AAAA_5555AAAA, 8'h0F, 8'h3C,
                64'h0, 2, 1'b1, 1'b0, 1'b1, 64'h5000, 64'h5555AAAA_5555AAAA, 8'h3C, 32'h0};

    // Reset values.
    do_reset();
    #1;
    chk("rst_strobes", 64'({mem_re, mem_we}), 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_w", mem_w, 64'h0);
    chk("rst_mem_sel", 64'(mem_sel), 64'h0);
    chk("rst_err", 64'(err_timeout), 64'h0);
    chk("rst_acks", 64'({instr_ack, data_ack}), 64'h0);

    // Slave ack while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_r = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk("idle_ack_acks", 64'({instr_ack, data_ack}), 64'h0);
      chk("idle_ack_data", {instr_data, data_r[31:0]}, 64'h0);
      chk("idle_ack_strobes", 64'({mem_re, mem_we}), 64'h0);
    end
    @(negedge clk);
    mem_ack = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Watchdog: data read never acked.
    @(negedge clk);
    data_re = 1'b1; data_addr = 64'h3000; data_sel = 8'hFF;
    #1;
    for (int a = 1; a <= 4; a++) begin
      @(negedge clk);
      #1;
      chk("tmo_data_ack", 64'(data_ack), 64'(a == 4));
      chk("tmo_data_r", data_r, 64'h0);
      chk("tmo_err_pre", 64'(err_timeout), 64'h0);
    end
    @(negedge clk);
    data_re = 1'b0;
    instr_re = 1'b1; instr_addr = 64'h1004; instr_sel = 8'hFF;
    #1;
    chk("tmo_err_set", 64'(err_timeout), 64'h1);
    chk("tmo_gap_strobe", 64'(mem_re), 64'h0);
    @(negedge clk);
    mem_ack = 1'b1; mem_r = 64'h0BADF00D_00000000;
    #1;
    chk("tmo_next_mem_re", 64'(mem_re), 64'h1);
    chk("tmo_next_addr", mem_addr, 64'h1004);
    chk("tmo_next_ack", 64'(instr_ack), 64'h1);
    chk("tmo_next_data", 64'(instr_data), 64'h0BADF00D);
    chk("tmo_err_sticky", 64'(err_timeout), 64'h1);
    @(negedge clk);
    idle_inputs();

    // Reset in the middle of a data transaction.
    @(negedge clk);
    data_re = 1'b1; data_addr = 64'h6000;
    @(negedge clk);
    #1 chk("rstmid_busy", 64'(mem_re), 64'h1);
    @(negedge clk);
    mem_ack = 1'b1; mem_r = 64'h1234;
    reset_n = 1'b0;
    #1;
    chk("rstmid_strobes", 64'({mem_re, mem_we}), 64'h0);
    chk("rstmid_no_ack", 64'(data_ack), 64'h0);
    chk("rstmid_err_clr", 64'(err_timeout), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();

    // Continuous requests from both masters: I, D, I, D with idle gaps.
    @(negedge clk);
    instr_re = 1'b1; instr_addr = 64'h1100; instr_sel = 8'hFF;
    data_re = 1'b1; data_addr = 64'h2200; data_sel = 8'hFF;
    #1 chk("rr_first_idle", 64'({mem_re, mem_we}), 64'h0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("rr_mem_re", 64'(mem_re), 64'h1);
      chk("rr_mem_addr", mem_addr, (t % 2 == 0) ? 64'h1100 : 64'h2200);
      @(negedge clk);
      mem_ack = 1'b1; mem_r = 64'h0;
      #1;
      chk("rr_instr_ack", 64'(instr_ack), 64'(t % 2 == 0));
      chk("rr_data_ack", 64'(data_ack), 64'(t % 2 == 1));
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("rr_gap", 64'({mem_re, mem_we}), 64'h0);
      chk("rr_gap_acks", 64'({instr_ack, data_ack}), 64'h0);
    end
    @(negedge clk);
    idle_inputs();

    // Randomized traffic against a transaction-level reference.
    do_reset();
    m_own = 0; m_age = 0; m_lat = 1; m_last_d = 1'b1; m_err = 1'b0;
    pi = 1'b0; pd = 1'b0; dre_r = 1'b0; dwe_r = 1'b0;
    c_re = 1'b0; c_we = 1'b0; c_addr = 64'h0; c_w = 64'h0; c_sel = 8'h0;
    ia = 64'h0; da = 64'h0; dw = 64'h0; isel_r = 8'h0; dsel_r = 8'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (!pi) begin
        ia = {$urandom, $urandom} & ~64'h3;
        isel_r = 8'($urandom);
        pi = ($urandom_range(0, 2) == 0);
      end
      if (!pd) begin
        int k;
        da = {$urandom, $urandom};
        dw = {$urandom, $urandom};
        dsel_r = 8'($urandom);
        k = $urandom_range(0, 2);
        dre_r = (k != 1);
        dwe_r = (k != 0);
        pd = ($urandom_range(0, 2) == 0);
      end
      instr_re = pi; instr_addr = ia; instr_sel = isel_r;
      data_re = pd & dre_r; data_we = pd & dwe_r;
      data_addr = da; data_w = dw; data_sel = dsel_r;
      mr = {$urandom, $urandom};
      ack = (m_own != 0) ? (m_age == m_lat) : ($urandom_range(0, 7) == 0);
      mem_ack = ack; mem_r = mr;
      #1;
      expire = (m_own != 0) && (m_age == int'(TMO)) && !ack;
      done   = (m_own != 0) && (ack || expire);
      chk("rnd_instr_ack", 64'(instr_ack), 64'(done && m_own == 1));
      chk("rnd_data_ack", 64'(data_ack), 64'(done && m_own == 2));
      chk("rnd_instr_data", 64'(instr_data),
          (m_own == 1 && ack) ? 64'(c_addr[2] ? mr[63:32] : mr[31:0]) : 64'h0);
      chk("rnd_data_r", data_r, (m_own == 2 && ack) ? mr : 64'h0);
      chk("rnd_strobes", 64'({mem_re, mem_we}), (m_own != 0) ? 64'({c_re, c_we}) : 64'h0);
      if (m_own != 0) begin
        chk("rnd_mem_addr", mem_addr, c_addr);
        chk("rnd_mem_w", mem_w, c_w);
        chk("rnd_mem_sel", 64'(mem_sel), 64'(c_sel));
      end
      chk("rnd_err", 64'(err_timeout), 64'(m_err));
      if (done) begin
        if (expire) m_err = 1'b1;
        if (m_own == 1) pi = 1'b0; else pd = 1'b0;
        m_own = 0;
      end else if (m_own != 0) begin
        m_age++;
      end else if (pi || pd) begin
        if (pi && pd) m_own = m_last_d ? 1 : 2;
        else          m_own = pi ? 1 : 2;
        m_last_d = (m_own == 2);
        if (m_own == 1) begin
          c_re = 1'b1; c_we = 1'b0; c_addr = ia; c_w = 64'h0; c_sel = isel_r;
        end else begin
          c_we = dwe_r; c_re = dre_r & ~dwe_r; c_addr = da; c_w = dw; c_sel = dsel_r;
        end
        m_age = 1;
        m_lat = $urandom_range(1, 6);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c2c_mem_arbiter.md
Name: c2c_mem_arbiter

Overview:
- Shares one memory slave port between the core's instruction-fetch master and data master.
- Sits between the core's external instruction and data bus pins and a single unified memory or bus-bridge port.
- Round-robin arbitration and one outstanding transaction at a time.
- Registered memory-side command outputs; a watchdog forces completion of hung transactions.

Parameters:
- XLEN, pipeline::XLEN (64), width of data and address.
- TIMEOUT_CYCLES, 255, BUSY cycles allowed before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_re  in  1  fetch request; held until instr_ack.
- instr_sel  in  XLEN/8  fetch byte select.
- instr_addr  in  XLEN  fetch address.
- instr_ack  out  1  fetch complete, one-cycle pulse.
- instr_data  out  32  fetched instruction, valid with instr_ack.
- data_re  in  1  load request; held until data_ack.
- data_we  in  1  store request; held until data_ack.
- data_sel  in  XLEN/8  byte select.
- data_addr  in  XLEN  address.
- data_w  in  XLEN  store data.
- data_ack  out  1  load/store complete, one-cycle pulse.
- data_r  out  XLEN  load data, valid with data_ack.
- mem_re  out  1  memory read strobe (registered).
- mem_we  out  1  memory write strobe (registered).
- mem_sel  out  XLEN/8  registered byte select.
- mem_addr  out  XLEN  registered address.
- mem_w  out  XLEN  registered write data.
- mem_ack  in  1  memory completion.
- mem_r  in  XLEN  memory read data, valid with mem_ack.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; last_grant = DATA.
  - mem_re, mem_we, mem_sel, mem_addr, mem_w = 0.
  - Watchdog counter = 0; err_timeout = 0.
  - Any in-flight transaction is dropped; no ack is issued for it.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Requesters: I = instr_re; D = data_re | data_we.
  - One requester: grant it.
  - Both: grant the one that is not last_grant.
  - On grant: register the winner's addr/sel/w into the mem_* outputs; set mem_re/mem_we; update last_grant; next state BUSY_I or BUSY_D.
  - Instruction grant: mem_re=1, mem_we=0, mem_w=0.
  - Data grant: mem_we=data_we, mem_re=data_re & ~data_we (write wins if both asserted).
  - No request: stay in IDLE, mem strobes 0.
- BUSY_x:
  - mem_* outputs held stable; master-side inputs are ignored.
  - On mem_ack: drive the owner's ack=1 combinationally in that cycle and route data.
    - instr_data = XLEN==64 ? (mem_addr[2] ? mem_r[63:32] : mem_r[31:0]) : mem_r[31:0].
    - data_r = mem_r.
  - Next cycle: state IDLE, mem_re=mem_we=0.
- Acks are never asserted outside BUSY_x or to the non-owner.
- instr_data and data_r are 0 when their ack is low.
- mem_ack in IDLE is ignored.
- Latency:
  - Request seen in IDLE at cycle N → mem strobe at N+1.
  - mem_ack at N+k (k≥1) → master ack at N+k.
  - Back-to-back transactions are separated by at least one IDLE cycle (strobes low).
- Fairness:
  - With continuous requests from both masters, grants alternate I, D, I, D...
  - First tie after reset goes to instruction.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entering BUSY and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT_CYCLES with no mem_ack: pulse the owner's ack with zero data, set err_timeout (sticky until reset), go to IDLE.
  - mem_ack in the same cycle as expiry takes precedence: normal completion, no error.
- A master dropping its request while BUSY does not abort the transaction; its ack is still issued.

Decomposition:
- Shared package c2c_pkg:
  - typedef enum {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_e.
  - typedef enum logic {GRANT_INSTR, GRANT_DATA} arb_grant_e.
  - XLEN stays imported from pipeline.
- Sub-module c2c_rr_pick2 (combinational two-way round-robin pick: req_i, req_d, last → grant); reusable for future peripheral arbiters.

Test Plan:
- Reset, then instr_re=1, instr_addr=0x1004, mem_ack one cycle after mem_re, mem_r=0xDEADBEEF_12345678 → mem_re=1, mem_addr=0x1004 one cycle after request; instr_ack with instr_data=0xDEADBEEF.
- instr_re and data_re asserted together, held continuously, mem_ack latency 2 → grant order I, D, I, D; one IDLE cycle between strobes; no simultaneous acks.
- data_we=1 and data_re=1, data_addr=0x2000, data_w=0xA5A5..., data_sel=0x0F → mem_we=1, mem_re=0, mem_w and mem_sel match; data_ack on mem_ack.
- TIMEOUT_CYCLES=4, data_re held, mem_ack never asserted → data_ack with data_r=0 on the 4th BUSY cycle; err_timeout=1 stays set; next instr request is served normally.
- Assert reset_n=0 mid-BUSY_D → mem_re/mem_we drop immediately; no data_ack; after release, the first tie grants instruction.
- mem_ack asserted in IDLE with no request → no ack outputs, state stays IDLE.
